// File: rtl/fb_ctrl.sv
// Frame-buffer controller: arbitrates the BSRAM write port between host pixel
// writes and a full-buffer fill engine, and drives the read port as a raster scan-out.
module fb_ctrl #(
  parameter int H_RES  = 256,
  parameter int V_RES  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic [1:0]        clear_val,
  output logic              busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [1:0]        wr_data,
  output logic              err_oob,
  input  logic              rd_start,
  input  logic              rd_en,
  output logic              pix_valid,
  output logic [1:0]        pix_data,
  output logic              frame_done,
  output logic              ram_cea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [1:0]        ram_din,
  output logic              ram_ceb,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_oce,
  input  logic [1:0]        ram_dout
);

  localparam int                NPIX      = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_CLEAR  = 1'b1;
  localparam logic [0:0] R_WAIT   = 1'b0;
  localparam logic [0:0] R_ACTIVE = 1'b1;

  logic [0:0]        wr_state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic [1:0]        clr_val_r;
  logic              err_oob_r;
  logic              ram_cea_r;
  logic [ADDR_W-1:0] ram_ada_r;
  logic [1:0]        ram_din_r;
  logic [0:0]        rd_state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              pix_valid_r;
  logic              frame_done_r;

  logic              wr_ready_s;
  logic              clr_start_s;
  logic              wr_fire_s;
  logic              oob_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              ram_ceb_s;

  // Write-side handshake decode: a clear request always takes the port from the host.
  always_comb begin
    wr_ready_s  = 1'b0;
    clr_start_s = 1'b0;
    if (wr_state_r == W_IDLE) begin
      wr_ready_s  = !clear_req;
      clr_start_s = clear_req;
    end else begin
      wr_ready_s  = 1'b0;
      clr_start_s = 1'b0;
    end
    wr_fire_s = wr_valid && wr_ready_s;
    oob_s     = ({24'd0, wr_x} >= 32'(H_RES)) || ({24'd0, wr_y} >= 32'(V_RES));
    wr_addr_s = ADDR_W'({24'd0, wr_y} * 32'(H_RES) + {24'd0, wr_x});
  end

  // Write FSM and registered write port; the first fill word is issued alongside busy rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_r <= W_IDLE;
      clr_cnt_r  <= ADDR_ZERO;
      clr_val_r  <= 2'b00;
      err_oob_r  <= 1'b0;
      ram_cea_r  <= 1'b0;
      ram_ada_r  <= ADDR_ZERO;
      ram_din_r  <= 2'b00;
    end else begin
      ram_cea_r <= 1'b0;
      ram_ada_r <= ADDR_ZERO;
      ram_din_r <= 2'b00;
      case (wr_state_r)
        W_IDLE: begin
          if (clr_start_s) begin
            wr_state_r <= W_CLEAR;
            clr_val_r  <= clear_val;
            clr_cnt_r  <= ADDR_ZERO;
            ram_cea_r  <= 1'b1;
            ram_din_r  <= clear_val;
          end else if (wr_fire_s) begin
            if (oob_s) begin
              err_oob_r <= 1'b1;
            end else begin
              ram_cea_r <= 1'b1;
              ram_ada_r <= wr_addr_s;
              ram_din_r <= wr_data;
            end
          end
        end
        W_CLEAR: begin
          // clr_cnt_r tracks the address currently on the port, so it never passes LAST_ADDR.
          if (clr_cnt_r == LAST_ADDR) begin
            wr_state_r <= W_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_ONE;
            ram_cea_r <= 1'b1;
            ram_ada_r <= clr_cnt_r + ADDR_ONE;
            ram_din_r <= clr_val_r;
          end
        end
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  // Read strobe: rd_start takes priority so a restarted frame always begins at address 0.
  always_comb begin
    if ((rd_state_r == R_ACTIVE) && !rd_start) begin
      ram_ceb_s = rd_en;
    end else begin
      ram_ceb_s = 1'b0;
    end
  end

  // Read FSM, scan address and the output-valid/frame-done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_r   <= R_WAIT;
      rd_addr_r    <= ADDR_ZERO;
      pix_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      pix_valid_r  <= ram_ceb_s;
      frame_done_r <= ram_ceb_s && (rd_addr_r == LAST_ADDR);
      if (rd_start) begin
        rd_state_r <= R_ACTIVE;
        rd_addr_r  <= ADDR_ZERO;
      end else if (ram_ceb_s) begin
        if (rd_addr_r == LAST_ADDR) begin
          rd_state_r <= R_WAIT;
        end else begin
          rd_addr_r <= rd_addr_r + ADDR_ONE;
        end
      end
    end
  end

  assign busy       = (wr_state_r == W_CLEAR);
  assign wr_ready   = wr_ready_s;
  assign err_oob    = err_oob_r;
  assign ram_cea    = ram_cea_r;
  assign ram_ada    = ram_ada_r;
  assign ram_din    = ram_din_r;
  assign ram_ceb    = ram_ceb_s;
  assign ram_adb    = rd_addr_r;
  assign ram_oce    = 1'b1;
  assign pix_valid  = pix_valid_r;
  assign frame_done = frame_done_r;
  assign pix_data   = pix_valid_r ? ram_dout : 2'b00;

endmodule

// File: doc/fb_ctrl.md
# fb_ctrl

Frame-buffer controller for the 2-bit-per-pixel, 64K-entry simple-dual-port BSRAM frame buffer. It arbitrates the write port between a host pixel writer and an internal clear/fill engine. It also sequences the read port as a raster scan-out stream for the display timing block. Both RAM ports run on the single system clock (clka = clkb = clk).

## Interface
- H_RES, 256: active pixels per line.
- V_RES, 256: active lines per frame.
- Constraint: H_RES*V_RES ≤ 65536.
- ADDR_W, 16: RAM address width.

- clk  in  1  system clock; drives both RAM ports.
- rst_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle pulse; starts a full-buffer fill.
- clear_val  in  2  fill value; sampled when clear_req is accepted.
- busy  out  1  clear in progress.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle if wr_valid=1.
- wr_x  in  8  host pixel column.
- wr_y  in  8  host pixel row.
- wr_data  in  2  host pixel value.
- err_oob  out  1  sticky; an out-of-range host write was dropped.
- rd_start  in  1  frame-start pulse from display timing.
- rd_en  in  1  display requests the next pixel.
- pix_valid  out  1  pix_data is valid.
- pix_data  out  2  scanned pixel value.
- frame_done  out  1  one-cycle pulse after the last pixel is delivered.
- ram_cea  out  1  write enable to the RAM A port.
- ram_ada  out  ADDR_W  write address.
- ram_din  out  2  write data.
- ram_ceb  out  1  read enable.
- ram_adb  out  ADDR_W  read address.
- ram_oce  out  1  tied to 1.
- ram_dout  in  2  RAM read data.

## Operation
**Write side: FSM with states W_IDLE and W_CLEAR. Reset state is W_IDLE.**
- W_IDLE:
  - wr_ready = !clear_req.
  - A handshake (wr_valid & wr_ready) writes wr_data at address wr_y*H_RES + wr_x.
  - If wr_x ≥ H_RES or wr_y ≥ V_RES: the write is accepted but not issued (ram_cea=0), and err_oob is set.
  - err_oob clears only on reset.
- clear_req in W_IDLE:
  - Latch clear_val, zero the clear counter, go to W_CLEAR.
  - clear_req wins over a simultaneous wr_valid; that host write is not accepted.
- W_CLEAR:
  - wr_ready=0, busy=1.
  - Each cycle: write the latched value at the clear counter address, then increment.
  - After the write to address H_RES*V_RES-1, return to W_IDLE.
  - clear_req in W_CLEAR is ignored (no restart).
- Write-port outputs are registered:
  - ram_cea/ram_ada/ram_din present the accepted write the cycle after the handshake.
  - All write-port outputs are 0 when no write is issued.

**Read side: FSM with states R_WAIT and R_ACTIVE. Reset state is R_WAIT.**
- rd_start (in either state): zero the read address, go to R_ACTIVE.
  - rd_start mid-frame aborts the current frame; frame_done is not pulsed for it.
- R_ACTIVE, rd_en=1:
  - ram_ceb=1, ram_adb = current read address (combinational from the address register).
  - Increment the address.
- R_ACTIVE, rd_en=0: ram_ceb=0, address holds.
- When the address H_RES*V_RES-1 is issued, go to R_WAIT.
  - frame_done pulses in the same cycle that pixel's pix_valid is high.
- R_WAIT:
  - rd_en is ignored, ram_ceb=0.
  - ram_adb holds its last value.
- pix_valid is the registered ram_ceb.
- pix_data = ram_dout when pix_valid, else 0.
- Read/write collision: the same address read and written in the same cycle returns unspecified data. The controller does not interlock this case.

## Timing
- Reset values (all asserted while rst_n=0):
  - busy=0, wr_ready=1, err_oob=0.
  - pix_valid=0, pix_data=0, frame_done=0.
  - ram_cea=0, ram_ada=0, ram_din=0.
  - ram_ceb=0, ram_adb=0, ram_oce=1.
- Host write latency: handshake at cycle N, RAM write strobe at N+1. Throughput is one write per cycle.
- Clear:
  - busy rises the cycle after the clear_req pulse.
  - The first RAM write occurs in that same cycle.
  - busy stays high for exactly H_RES*V_RES cycles.
  - wr_ready returns high the cycle busy falls.
- Read latency: rd_en high at cycle N produces pix_valid/pix_data at N+1 (bypass read mode plus the output-mux register). Throughput is one pixel per cycle.
- Wrap: the read and clear counters stop at H_RES*V_RES-1 and never wrap past it.
- Reset mid-operation returns both FSMs to their idle states. A partial clear leaves RAM contents undefined.

## Test plan
- Reset, then host write (x=3, y=2, data=2'b10) → ram_cea=1, ram_ada=0x0203, ram_din=2'b10 one cycle later. err_oob=0.
- Host write (x=255, y=255, data=1) then read of that frame position → pix_data=1 on the last pixel, together with frame_done.
- clear_req with clear_val=2'b01, wr_valid held high → busy high for exactly 65536 cycles, wr_ready=0 throughout, no host write accepted. A full frame read returns all 2'b01.
- clear_req and wr_valid in the same cycle → no host write accepted; the clear proceeds.
- rd_start, then rd_en toggled 1,0,1 → ram_adb 0, (hold), 1. pix_valid follows rd_en one cycle later.
- Out-of-range write (H_RES=200, x=210) → no RAM write, err_oob=1 sticky.
- rd_start at pixel 100 of a frame → the next issued address is 0, and no frame_done occurs for the aborted frame.
- rst_n low mid-clear → busy=0 and wr_ready=1 immediately; after release, a new clear completes normally.
